// File: rtl/cmul_seq.sv
// Sequential complex multiplier: issues four real products to an external multiplier,
// accumulates them and rescales to Q1.(WIDTH-1). Define CMUL_ROUND_EN for round-half-up scaling.
module cmul_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PWIDTH = 2 * WIDTH - 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  ar,
  input  logic [WIDTH-1:0]  ai,
  input  logic [WIDTH-1:0]  br,
  input  logic [WIDTH-1:0]  bi,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  output logic              mul_start,
  input  logic              mul_ready,
  input  logic [PWIDTH-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_re,
  output logic [WIDTH-1:0]  out_im
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned EW = AW + 1;
  localparam logic signed [EW-1:0] SAT_HI = EW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [EW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCALE, OUT} state_t;

  state_t                state, state_d;
  logic [1:0]            k, k_d;
  logic signed [AW-1:0]  acc_re, acc_re_d, acc_im, acc_im_d;
  logic [WIDTH-1:0]      ar_q, ai_q, br_q, bi_q;
  logic [WIDTH-1:0]      ar_d, ai_d, br_d, bi_d;
  logic [WIDTH-1:0]      mul_a_d, mul_b_d, out_re_d, out_im_d;
  logic                  mul_start_d, out_valid_d, in_ready_d;
  logic                  first_wait, first_wait_d;
  logic signed [AW-1:0]  prod_ext;

  assign prod_ext = AW'($signed(mul_product));

  // Shift right by WIDTH-1 (optionally rounded) and clamp into the output range
  function automatic logic [WIDTH-1:0] scale_sat(input logic signed [AW-1:0] a);
    logic signed [EW-1:0] t;
    t = EW'(a);
`ifdef CMUL_ROUND_EN
    t = t + (EW'(1) << (WIDTH - 2));
`endif
    t = t >>> (WIDTH - 1);
    if (t > SAT_HI) return SAT_HI[WIDTH-1:0];
    else if (t < SAT_LO) return SAT_LO[WIDTH-1:0];
    else return t[WIDTH-1:0];
  endfunction

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
      ar_q       <= '0;
      ai_q       <= '0;
      br_q       <= '0;
      bi_q       <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      in_ready   <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      state      <= state_d;
      k          <= k_d;
      acc_re     <= acc_re_d;
      acc_im     <= acc_im_d;
      ar_q       <= ar_d;
      ai_q       <= ai_d;
      br_q       <= br_d;
      bi_q       <= bi_d;
      mul_a      <= mul_a_d;
      mul_b      <= mul_b_d;
      mul_start  <= mul_start_d;
      out_valid  <= out_valid_d;
      out_re     <= out_re_d;
      out_im     <= out_im_d;
      in_ready   <= in_ready_d;
      first_wait <= first_wait_d;
    end
  end

  // Next-state and registered-output logic; mul_start is raised on entry to ISSUE
  always_comb begin
    state_d      = state;
    k_d          = k;
    acc_re_d     = acc_re;
    acc_im_d     = acc_im;
    ar_d         = ar_q;
    ai_d         = ai_q;
    br_d         = br_q;
    bi_d         = bi_q;
    mul_a_d      = mul_a;
    mul_b_d      = mul_b;
    mul_start_d  = 1'b0;
    out_valid_d  = 1'b0;
    out_re_d     = out_re;
    out_im_d     = out_im;
    in_ready_d   = 1'b0;
    first_wait_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          ar_d        = ar;
          ai_d        = ai;
          br_d        = br;
          bi_d        = bi;
          acc_re_d    = '0;
          acc_im_d    = '0;
          k_d         = 2'd0;
          mul_a_d     = ar;
          mul_b_d     = br;
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        first_wait_d = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // The first WAIT cycle may still see a stale ready level from the previous product
        if (!first_wait && mul_ready) begin
          unique case (k)
            2'd0:    acc_re_d = acc_re + prod_ext;
            2'd1:    acc_re_d = acc_re - prod_ext;
            default: acc_im_d = acc_im + prod_ext;
          endcase
          if (k == 2'd3) begin
            state_d = SCALE;
          end else begin
            k_d         = k + 2'd1;
            mul_a_d     = k_d[0] ? ai_q : ar_q;
            mul_b_d     = (k_d[0] ^ k_d[1]) ? bi_q : br_q;
            mul_start_d = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      SCALE: begin
        out_re_d    = scale_sat(acc_re);
        out_im_d    = scale_sat(acc_im);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_valid && out_ready) begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmul_seq.sv
// Directed-vector bench for cmul_seq with a fixed three-cycle multiplier model.
module tb_cmul_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned PWIDTH = 16;

`ifdef CMUL_ROUND_EN
  localparam int EXP_P1 = 1;
  localparam int EXP_M1 = 0;
`else
  localparam int EXP_P1 = 0;
  localparam int EXP_M1 = -1;
`endif

  logic              clkin = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  ar = '0, ai = '0, br = '0, bi = '0;
  logic [WIDTH-1:0]  mul_a, mul_b;
  logic              mul_start;
  logic              mul_ready;
  logic [PWIDTH-1:0] mul_product;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_re, out_im;

  int checks = 0;
  int errors = 0;

  cmul_seq #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) dut (
    .clkin(clkin), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im)
  );

  always #5 clkin = ~clkin;

  // Multiplier model: ready rises in the third cycle after the start pulse is sampled
  int cnt = 0;
  int pulses = 0;
  logic [WIDTH-1:0] rec_a [64];
  logic [WIDTH-1:0] rec_b [64];

  always @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt         <= 0;
      mul_ready   <= 1'b0;
      mul_product <= '0;
    end else if (mul_start) begin
      cnt                <= 1;
      mul_ready          <= 1'b0;
      mul_product        <= 16'($signed(mul_a)) * 16'($signed(mul_b));
      rec_a[pulses % 64] <= mul_a;
      rec_b[pulses % 64] <= mul_b;
      pulses             <= pulses + 1;
    end else if (cnt == 1 || cnt == 2) begin
      cnt <= cnt + 1;
      if (cnt == 2) mul_ready <= 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer operands, then count cycles from the accept edge until out_valid
  task automatic run_op(input logic [WIDTH-1:0] a_r, a_i, b_r, b_i, output int lat);
    int guard;
    ar = a_r; ai = a_i; br = b_r; bi = b_i;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clkin); #1;
      guard++;
    end
    @(posedge clkin); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clkin); #1;
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clkin); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  typedef struct {
    logic signed [7:0] ar, ai, br, bi;
    int re, im;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, p0, ord_err, seen_v, seen_s;
    logic [WIDTH-1:0] ea[4];
    logic [WIDTH-1:0] eb[4];

    vecs[0] = '{8'sd64,   8'sd0,    8'sd64,   8'sd0,    32,     0};
    vecs[1] = '{8'sd64,   8'sd64,   8'sd64,  -8'sd64,   64,     0};
    vecs[2] = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, 0,      127};
    vecs[3] = '{8'sd1,    8'sd0,    8'sd64,   8'sd0,    EXP_P1, 0};
    vecs[4] = '{-8'sd1,   8'sd0,    8'sd64,   8'sd0,    EXP_M1, 0};
    vecs[5] = '{8'sd127,  8'sd127,  8'sd127,  8'sd127,  0,      127};
    vecs[6] = '{8'sd32,  -8'sd16,   8'sd16,   8'sd48,   10,     10};
    vecs[7] = '{-8'sd128, 8'sd127,  8'sd127,  8'sd127, -128,   -1};

    // Reset values while rst is held
    #1;
    chk("rst_mul_start", int'(mul_start), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    @(posedge clkin); @(posedge clkin); #1;
    rst = 1'b0;
    @(posedge clkin); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    for (int v = 0; v < 8; v++) begin
      p0 = pulses;
      run_op(vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi, lat);
      chk($sformatf("v%0d_latency", v), lat, 17);
      chk($sformatf("v%0d_re", v), int'($signed(out_re)), vecs[v].re);
      chk($sformatf("v%0d_im", v), int'($signed(out_im)), vecs[v].im);
      chk($sformatf("v%0d_pulses", v), pulses - p0, 4);
      ea = '{vecs[v].ar, vecs[v].ai, vecs[v].ar, vecs[v].ai};
      eb = '{vecs[v].br, vecs[v].bi, vecs[v].bi, vecs[v].br};
      ord_err = 0;
      for (int j = 0; j < 4; j++)
        if (rec_a[(p0 + j) % 64] != ea[j] || rec_b[(p0 + j) % 64] != eb[j]) ord_err++;
      chk($sformatf("v%0d_operand_order", v), ord_err, 0);
      finish_op($sformatf("v%0d", v));
    end

    // Output stall: result held, new operands ignored
    run_op(8'sd64, 8'sd0, 8'sd64, 8'sd0, lat);
    chk("stall_latency", lat, 17);
    p0 = pulses;
    ar = 8'sd5; ai = 8'sd5; br = 8'sd5; bi = 8'sd5;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clkin); #1;
      chk($sformatf("stall%0d_valid", c), int'(out_valid), 1);
      chk($sformatf("stall%0d_re", c), int'($signed(out_re)), 32);
      chk($sformatf("stall%0d_im", c), int'($signed(out_im)), 0);
      chk($sformatf("stall%0d_in_ready", c), int'(in_ready), 0);
    end
    chk("stall_no_pulse", pulses - p0, 0);
    in_valid = 1'b0;
    finish_op("stall");

    // Reset during WAIT abandons the operation
    ar = 8'sd64; ai = 8'sd0; br = 8'sd64; bi = 8'sd0;
    in_valid = 1'b1;
    @(posedge clkin); #1;
    in_valid = 1'b0;
    @(posedge clkin); #1;
    @(posedge clkin); #1;
    rst = 1'b1;
    #1;
    chk("midrst_mul_start", int'(mul_start), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_re", int'(out_re), 0);
    chk("midrst_out_im", int'(out_im), 0);
    chk("midrst_mul_a", int'(mul_a), 0);
    chk("midrst_mul_b", int'(mul_b), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clkin); #1;
    rst = 1'b0;
    p0 = pulses;
    @(posedge clkin); #1;
    chk("midrst_in_ready_after", int'(in_ready), 1);
    seen_v = 0; seen_s = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clkin); #1;
      if (out_valid) seen_v++;
      if (mul_start) seen_s++;
    end
    chk("midrst_no_out_valid", seen_v, 0);
    chk("midrst_no_mul_start", seen_s + (pulses - p0), 0);

    // Normal operation resumes after the abandoned one
    run_op(vecs[6].ar, vecs[6].ai, vecs[6].br, vecs[6].bi, lat);
    chk("recover_latency", lat, 17);
    chk("recover_re", int'($signed(out_re)), 10);
    chk("recover_im", int'($signed(out_im)), 10);
    finish_op("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
